branch_predictor: RTL and testbench

Dynamic branch predictor for the 5-stage RV32I pipeline. A direct-mapped branch target buffer (BTB) of 2-bit saturating counters with tags and targets sits at fetch and supplies a predicted next PC. At execute, the block compares the predicted outcome with the resolved outcome. It drives the mispredict/redirect pair that the hazard unit uses to decide PCSrc and Flush. This replaces static predict-not-taken.

---
 rtl/branch_predictor.sv | 115 +++++++++++
 tb/tb_branch_predictor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with 2-bit saturating counters, fetch lookup and execute resolution.
// Optional statistics counters are enabled by defining BP_STATS_EN.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] F_pc,
  output logic            F_pred_taken,
  output logic [XLEN-1:0] F_pred_target,
  input  logic            E_update,
  input  logic            E_is_jump,
  input  logic [XLEN-1:0] E_pc,
  input  logic            E_taken,
  input  logic [XLEN-1:0] E_target,
  input  logic            E_pred_taken,
  input  logic [XLEN-1:0] E_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = XLEN - INDEX_BITS - 2;

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, e_idx;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic                  f_hit, e_hit, actual;
  logic [1:0]            ctr_next;

  assign f_idx = F_pc[INDEX_BITS+1:2];
  assign f_tag = F_pc[XLEN-1:INDEX_BITS+2];
  assign e_idx = E_pc[INDEX_BITS+1:2];
  assign e_tag = E_pc[XLEN-1:INDEX_BITS+2];

  // Fetch lookup reads pre-update table contents; no write bypass.
  always_comb begin
    f_hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    F_pred_taken  = f_hit && ctr_q[f_idx][1];
    F_pred_target = f_hit ? target_q[f_idx] : F_pc + XLEN'(4);
  end

  // Execute resolution; mispredict is forced low while reset is asserted.
  always_comb begin
    actual      = E_is_jump | E_taken;
    e_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
    mispredict  = rst_n && E_update &&
                  ((actual != E_pred_taken) ||
                   (actual && E_pred_taken && (E_target != E_pred_target)));
    redirect_pc = actual ? E_target : E_pc + XLEN'(4);
  end

  always_comb begin
    ctr_next = ctr_q[e_idx];
    if (E_is_jump) begin
      ctr_next = 2'b11;
    end else if (actual) begin
      if (ctr_q[e_idx] != 2'b11) ctr_next = ctr_q[e_idx] + 2'd1;
    end else begin
      if (ctr_q[e_idx] != 2'b00) ctr_next = ctr_q[e_idx] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (E_update) begin
      if (e_hit) begin
        ctr_q[e_idx] <= ctr_next;
      end else if (actual) begin
        valid_q[e_idx] <= 1'b1;
        ctr_q[e_idx]   <= E_is_jump ? 2'b11 : 2'b10;
      end
    end
  end

  // Tags and targets carry no reset; they are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst_n && E_update && actual) begin
      target_q[e_idx] <= E_target;
      if (!e_hit) tag_q[e_idx] <= e_tag;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branches_q, mispredicts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branches_q    <= '0;
      mispredicts_q <= '0;
    end else if (E_update) begin
      if (branches_q != 32'hFFFF_FFFF) branches_q <= branches_q + 32'd1;
      if (mispredict && (mispredicts_q != 32'hFFFF_FFFF)) mispredicts_q <= mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;
`else
  assign stat_branches    = 32'd0;
  assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor: directed scenarios plus randomized traffic checked
// against an array-based reference model of the BTB.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] F_pc;
  logic        F_pred_taken;
  logic [31:0] F_pred_target;
  logic        E_update, E_is_jump, E_taken, E_pred_taken;
  logic [31:0] E_pc, E_target, E_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  int total = 0;
  int bad   = 0;

  // Reference model: per-index owner tag (pc>>6), target and counter value 0..3.
  bit          mv  [16];
  logic [31:0] mt  [16];
  logic [31:0] mtg [16];
  int          mc  [16];
  int          n_br, n_mp;

  branch_predictor #(.INDEX_BITS(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .F_pc(F_pc), .F_pred_taken(F_pred_taken),
    .F_pred_target(F_pred_target), .E_update(E_update), .E_is_jump(E_is_jump),
    .E_pc(E_pc), .E_taken(E_taken), .E_target(E_target), .E_pred_taken(E_pred_taken),
    .E_pred_target(E_pred_target), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 1'b0;
      mc[i] = 1;
    end
    n_br = 0;
    n_mp = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
    int  idx = int'((pc >> 2) & 32'hF);
    bit  hit = mv[idx] && (mt[idx] == (pc >> 6));
    tk = hit && (mc[idx] >= 2);
    tg = hit ? mtg[idx] : pc + 32'd4;
  endfunction

  task automatic drive(input logic [31:0] fpc, input logic upd, input logic jmp,
                       input logic [31:0] epc, input logic tk, input logic [31:0] etg,
                       input logic ptk, input logic [31:0] ptg);
    F_pc = fpc; E_update = upd; E_is_jump = jmp; E_pc = epc;
    E_taken = tk; E_target = etg; E_pred_taken = ptk; E_pred_target = ptg;
  endtask

  // Checks all outputs against the model, then applies the clock edge to the model.
  task automatic cyc();
    logic        act, mp, ptk;
    logic [31:0] ptg, rd;
    int          idx;
    bit          hit;
    #1;
    m_lookup(F_pc, ptk, ptg);
    act = E_is_jump | E_taken;
    mp  = rst_n && E_update && ((act != E_pred_taken) ||
          (act && E_pred_taken && (E_target != E_pred_target)));
    rd  = act ? E_target : E_pc + 32'd4;
    check("pred_taken", 32'(F_pred_taken), 32'(ptk));
    check("pred_target", F_pred_target, ptg);
    check("mispredict", 32'(mispredict), 32'(mp));
    check("redirect_pc", redirect_pc, rd);
`ifdef BP_STATS_EN
    check("stat_branches", stat_branches, 32'(n_br));
    check("stat_mispredicts", stat_mispredicts, 32'(n_mp));
`else
    check("stat_branches", stat_branches, 32'd0);
    check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif
    @(posedge clk);
    if (rst_n && E_update) begin
      idx = int'((E_pc >> 2) & 32'hF);
      hit = mv[idx] && (mt[idx] == (E_pc >> 6));
      n_br++;
      if (mp) n_mp++;
      if (hit) begin
        if (E_is_jump)  mc[idx] = 3;
        else if (act)   mc[idx] = (mc[idx] == 3) ? 3 : mc[idx] + 1;
        else            mc[idx] = (mc[idx] == 0) ? 0 : mc[idx] - 1;
        if (act) mtg[idx] = E_target;
      end else if (act) begin
        mv[idx]  = 1'b1;
        mt[idx]  = E_pc >> 6;
        mtg[idx] = E_target;
        mc[idx]  = E_is_jump ? 3 : 2;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] epc, fpc, etg, ptg;
    logic        ptk;
    rst_n = 1'b0;
    m_reset();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    // Cold lookup and forced-quiet resolution during reset.
    drive(32'h100, 1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h0);
    #1;
    check("rst_pred_taken", 32'(F_pred_taken), 32'd0);
    check("rst_pred_target", F_pred_target, 32'h104);
    check("rst_mispredict", 32'(mispredict), 32'd0);
    check("rst_redirect", redirect_pc, 32'h44);
    cyc();
    rst_n = 1'b1;

    // Train branch at 0x100 taken to 0x080.
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h080, 1'b0, 32'h104);
    #1;
    check("train_mispredict", 32'(mispredict), 32'd1);
    check("train_redirect", redirect_pc, 32'h080);
    cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("trained_taken", 32'(F_pred_taken), 32'd1);
    check("trained_target", F_pred_target, 32'h080);
    cyc();

    // Saturate, then hysteresis on one not-taken.
    repeat (3) begin
      drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h080, 1'b1, 32'h080);
      cyc();
    end
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
    #1;
    check("hyst_mispredict", 32'(mispredict), 32'd1);
    check("hyst_redirect", redirect_pc, 32'h104);
    cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("hyst_still_taken", 32'(F_pred_taken), 32'd1);
    cyc();
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h080, 1'b1, 32'h080);
    cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("hyst_now_not_taken", 32'(F_pred_taken), 32'd0);
    cyc();

    // Alias miss and wrong-target correction.
    drive(32'h140, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("alias_no_hit", 32'(F_pred_taken), 32'd0);
    check("alias_target", F_pred_target, 32'h144);
    cyc();
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h0C0, 1'b1, 32'h080);
    #1;
    check("wrongtgt_mispredict", 32'(mispredict), 32'd1);
    check("wrongtgt_redirect", redirect_pc, 32'h0C0);
    cyc();
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("wrongtgt_stored", F_pred_target, 32'h0C0);
    cyc();

    // Same-cycle read/write returns old entry; then async reset mid-cycle.
    drive(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0C0, 1'b1, 32'h0C0);
    cyc();
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0C0, 1'b1, 32'h0C0);
    #1;
    check("samecyc_old_taken", 32'(F_pred_taken), 32'd1);
    cyc();
    drive(32'h100, 1'b1, 1'b0, 32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("async_pred_taken", 32'(F_pred_taken), 32'd0);
    check("async_mispredict", 32'(mispredict), 32'd0);
    cyc();
    rst_n = 1'b1;
    drive(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    check("cleared_taken", 32'(F_pred_taken), 32'd0);
    check("cleared_target", F_pred_target, 32'h104);
    cyc();

    // Five updates, two mispredicts.
    drive(32'h0, 1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204); cyc();
    drive(32'h0, 1'b1, 1'b0, 32'h200, 1'b1, 32'h300, 1'b1, 32'h300); cyc();
    drive(32'h0, 1'b1, 1'b0, 32'h204, 1'b0, 32'h300, 1'b0, 32'h208); cyc();
    drive(32'h0, 1'b1, 1'b0, 32'h208, 1'b0, 32'h300, 1'b1, 32'h20C); cyc();
    drive(32'h0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h300, 1'b1, 32'h300); cyc();
    drive(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
`ifdef BP_STATS_EN
    check("stats_branches5", stat_branches, 32'd5);
    check("stats_mispredicts2", stat_mispredicts, 32'd2);
`else
    check("stats_branches_off", stat_branches, 32'd0);
    check("stats_mispredicts_off", stat_mispredicts, 32'd0);
`endif
    cyc();

    // Randomized traffic over a small PC set to force hits, aliases and saturation.
    for (int n = 0; n < 600; n++) begin
      fpc = {24'h0, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)), 2'b00};
      epc = {24'h0, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)), 2'b00};
      etg = {20'h0, 4'($urandom_range(0, 3)), 6'($urandom), 2'b00};
      m_lookup(epc, ptk, ptg);
      if ($urandom_range(0, 4) == 0) ptk = ~ptk;
      if ($urandom_range(0, 4) == 0) ptg = etg;
      drive(fpc, ($urandom_range(0, 4) != 0), ($urandom_range(0, 6) == 0), epc,
            1'($urandom), etg, ptk, ptg);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
